// File: rtl/alarm_speaker_ctrl.sv
// Alarm speaker sequencer: tone, beep/gap cadence, timeout, stop and snooze.
// Optional STATUS read-back port enabled by defining ALARM_STATUS_PORT_EN.
module alarm_speaker_ctrl #(
    parameter int unsigned     TONE_DIV   = 25000,
    parameter int unsigned     BEEP_CYC   = 25_000_000,
    parameter int unsigned     GAP_CYC    = 25_000_000,
    parameter int unsigned     MAX_BEEPS  = 120,
    parameter longint unsigned SNOOZE_CYC = 64'd30_000_000_000,
    parameter logic [7:0]      CTRL_PORT  = 8'h0F,
    parameter logic [7:0]      STOP_KEY   = 8'h29,
    parameter logic [7:0]      SNZ_KEY    = 8'h5A
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ALARMA,
    input  logic [7:0] POR_ID,
    input  logic [7:0] OUT_PORT,
    input  logic       WRITE_STROBE,
    input  logic       KEY_VALID,
    input  logic [7:0] KEY_CODE,
    output logic       speaker,
    output logic       ALARM_ACTIVE
`ifdef ALARM_STATUS_PORT_EN
    ,
    output logic [7:0] STATUS
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BEEP   = 3'd1,
        GAP    = 3'd2,
        SNOOZE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam longint unsigned T1 =
        (BEEP_CYC > GAP_CYC) ? 64'(BEEP_CYC) : 64'(GAP_CYC);
    localparam longint unsigned TMAX =
        (SNOOZE_CYC > T1) ? SNOOZE_CYC : T1;
    localparam int CW = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    state_t        state_q;
    state_t        state_d;
    logic          alarm_q;
    logic          mute_q;
    logic [CW-1:0] cyc_q;
    logic [TW-1:0] tone_q;
    logic [7:0]    beep_cnt_q;
    logic          spk_q;

    logic wr_ctrl;
    logic stop;
    logic snooze;
    logic beep_end;
    logic gap_end;
    logic snz_end;

    assign wr_ctrl = WRITE_STROBE && (POR_ID == CTRL_PORT);
    assign stop    = (wr_ctrl && OUT_PORT[0])
                   || (KEY_VALID && (KEY_CODE == STOP_KEY));
    // stop takes priority when both arrive together
    assign snooze  = !stop
                   && ((wr_ctrl && OUT_PORT[1])
                   || (KEY_VALID && (KEY_CODE == SNZ_KEY)));

    assign beep_end = (cyc_q == CW'(BEEP_CYC - 1));
    assign gap_end  = (cyc_q == CW'(GAP_CYC - 1));
    assign snz_end  = (cyc_q == CW'(SNOOZE_CYC - 64'd1));

    assign speaker      = spk_q;
    assign ALARM_ACTIVE = (state_q == BEEP) || (state_q == GAP);

    // Next-state decode; mute overrides everything
    always_comb begin
        state_d = state_q;
        if (mute_q) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (ALARMA && !alarm_q) state_d = BEEP;
                end
                BEEP: begin
                    if (stop)             state_d = DONE;
                    else if (snooze)      state_d = SNOOZE;
                    else if (!ALARMA)     state_d = IDLE;
                    else if (beep_end)    state_d = GAP;
                end
                GAP: begin
                    if (stop)             state_d = DONE;
                    else if (snooze)      state_d = SNOOZE;
                    else if (!ALARMA)     state_d = IDLE;
                    else if (gap_end)
                        state_d = (beep_cnt_q == 8'(MAX_BEEPS)) ? DONE : BEEP;
                end
                SNOOZE: begin
                    if (stop)             state_d = DONE;
                    else if (!ALARMA)     state_d = IDLE;
                    else if (snz_end)     state_d = BEEP;
                end
                DONE: begin
                    if (!ALARMA)          state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, alarm edge history and sticky mute bit
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            alarm_q <= 1'b0;
            mute_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            alarm_q <= ALARMA;
            if (wr_ctrl) mute_q <= OUT_PORT[2];
        end
    end

    // Per-state cycle timer, cleared on entry and idle in untimed states
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cyc_q <= '0;
        end else if ((state_d != state_q) || (state_d == IDLE)
                     || (state_d == DONE)) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    // Tone generator; speaker is low outside a continuing beep
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tone_q <= '0;
            spk_q  <= 1'b0;
        end else if ((state_q == BEEP) && (state_d == BEEP)) begin
            if (tone_q == TW'(TONE_DIV - 1)) begin
                tone_q <= '0;
                spk_q  <= ~spk_q;
            end else begin
                tone_q <= tone_q + 1'b1;
            end
        end else begin
            tone_q <= '0;
            spk_q  <= 1'b0;
        end
    end

    // Beep counter: cleared on a fresh start, bumped at each beep end
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            beep_cnt_q <= '0;
        end else if ((state_d == BEEP)
                     && ((state_q == IDLE) || (state_q == SNOOZE))) begin
            beep_cnt_q <= '0;
        end else if ((state_q == BEEP) && (state_d == GAP)) begin
            beep_cnt_q <= beep_cnt_q + 1'b1;
        end
    end

`ifdef ALARM_STATUS_PORT_EN
    // Registered status byte for the processor input mux
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            STATUS <= 8'h00;
        end else begin
            STATUS <= {3'(state_q), mute_q,
                       (beep_cnt_q > 8'd15) ? 4'hF : beep_cnt_q[3:0]};
        end
    end
`endif

endmodule

// File: tb/tb_alarm_speaker_ctrl.sv
// Scoreboard bench for alarm_speaker_ctrl with shortened timing.
// Expected {speaker, ALARM_ACTIVE} queued per driven cycle, checked after edge.
module tb_alarm_speaker_ctrl;

    logic       CLK;
    logic       RST;
    logic       ALARMA;
    logic [7:0] POR_ID;
    logic [7:0] OUT_PORT;
    logic       WRITE_STROBE;
    logic       KEY_VALID;
    logic [7:0] KEY_CODE;
    logic       speaker;
    logic       ALARM_ACTIVE;

    int vectors;
    int miscompares;

    typedef struct {
        string      tag;
        logic [1:0] v;
    } exp_t;

    exp_t sb[$];

    alarm_speaker_ctrl #(
        .TONE_DIV  (2),
        .BEEP_CYC  (8),
        .GAP_CYC   (8),
        .MAX_BEEPS (3),
        .SNOOZE_CYC(64'd20)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ALARMA      (ALARMA),
        .POR_ID      (POR_ID),
        .OUT_PORT    (OUT_PORT),
        .WRITE_STROBE(WRITE_STROBE),
        .KEY_VALID   (KEY_VALID),
        .KEY_CODE    (KEY_CODE),
        .speaker     (speaker),
        .ALARM_ACTIVE(ALARM_ACTIVE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Expected tone level in beep cycle k for a half-period of 2
    function automatic logic spk_at(input int k);
        return ((k / 2) % 2) == 1;
    endfunction

    task automatic cyc(input string tag, input logic [1:0] e);
        exp_t x;
        exp_t y;
        x.tag = tag;
        x.v   = e;
        sb.push_back(x);
        @(posedge CLK);
        #1;
        y = sb.pop_front();
        check(y.tag, {6'b0, speaker, ALARM_ACTIVE}, {6'b0, y.v});
    endtask

    task automatic hold(input string tag, input int n, input logic [1:0] e);
        for (int i = 0; i < n; i++) cyc(tag, e);
    endtask

    task automatic beep_run(input string tag, input int from, input int to);
        for (int k = from; k <= to; k++) cyc(tag, {spk_at(k), 1'b1});
    endtask

    task automatic cyc_wr(input string tag, input logic [7:0] port,
                          input logic [7:0] data, input logic [1:0] e);
        POR_ID       = port;
        OUT_PORT     = data;
        WRITE_STROBE = 1'b1;
        cyc(tag, e);
        WRITE_STROBE = 1'b0;
        POR_ID       = 8'h00;
        OUT_PORT     = 8'h00;
    endtask

    task automatic cyc_key(input string tag, input logic [7:0] code,
                           input logic [1:0] e);
        KEY_CODE  = code;
        KEY_VALID = 1'b1;
        cyc(tag, e);
        KEY_VALID = 1'b0;
        KEY_CODE  = 8'h00;
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        RST          = 1'b0;
        ALARMA       = 1'b0;
        POR_ID       = 8'h00;
        OUT_PORT     = 8'h00;
        WRITE_STROBE = 1'b0;
        KEY_VALID    = 1'b0;
        KEY_CODE     = 8'h00;
        #3;
        check("rst_spk", {7'b0, speaker}, 8'h00);
        check("rst_act", {7'b0, ALARM_ACTIVE}, 8'h00);
        #9;
        RST = 1'b1;

        cyc("idle", 2'b00);

        // full cadence to auto-stop
        ALARMA = 1'b1;
        for (int b = 0; b < 3; b++) begin
            beep_run("beep", 0, 7);
            hold("gap", 8, 2'b01);
        end
        hold("done_hold", 3, 2'b00);
        ALARMA = 1'b0;
        cyc("done_idle", 2'b00);

        // port stop mid-beep
        ALARMA = 1'b1;
        beep_run("beep_a", 0, 3);
        cyc_wr("stop_wr", 8'h0F, 8'h01, 2'b00);
        hold("stop_done", 2, 2'b00);
        ALARMA = 1'b0;
        cyc("stop_idle", 2'b00);

        // key snooze in gap, then a fresh 3-beep run
        ALARMA = 1'b1;
        beep_run("beep_b", 0, 7);
        hold("gap_b", 2, 2'b01);
        cyc_key("snz_key", 8'h5A, 2'b00);
        hold("snooze", 19, 2'b00);
        for (int b = 0; b < 3; b++) begin
            beep_run("snz_beep", 0, 7);
            hold("snz_gap", 8, 2'b01);
        end
        hold("snz_done", 2, 2'b00);
        ALARMA = 1'b0;
        cyc("snz_idle", 2'b00);

        // port snooze, alarm drops during snooze
        ALARMA = 1'b1;
        beep_run("beep_c", 0, 1);
        cyc_wr("snz_wr", 8'h0F, 8'h02, 2'b00);
        hold("snz_c", 5, 2'b00);
        ALARMA = 1'b0;
        hold("snz_drop", 25, 2'b00);

        // stop and snooze together
        ALARMA = 1'b1;
        beep_run("beep_d", 0, 0);
        cyc_wr("both_wr", 8'h0F, 8'h03, 2'b00);
        hold("both_done", 25, 2'b00);
        ALARMA = 1'b0;
        cyc("both_idle", 2'b00);

        // mute blocks a rising alarm
        cyc_wr("mute_wr", 8'h0F, 8'h04, 2'b00);
        ALARMA = 1'b1;
        hold("muted", 4, 2'b00);
        cyc_wr("unmute", 8'h0F, 8'h00, 2'b00);
        hold("no_edge", 2, 2'b00);
        ALARMA = 1'b0;
        cyc("re_low", 2'b00);

        // mute during a beep
        ALARMA = 1'b1;
        beep_run("beep_e", 0, 0);
        cyc_wr("mute_beep", 8'h0F, 8'h04, {spk_at(1), 1'b1});
        cyc("mute_idle", 2'b00);
        cyc_wr("unmute2", 8'h0F, 8'h00, 2'b00);
        ALARMA = 1'b0;
        cyc("low2", 2'b00);

        // foreign port ignored, key stop honoured
        ALARMA = 1'b1;
        beep_run("beep_f", 0, 0);
        cyc_wr("other_port", 8'h0E, 8'h01, {spk_at(1), 1'b1});
        beep_run("beep_f", 2, 2);
        cyc_key("stop_key", 8'h29, 2'b00);
        hold("key_done", 2, 2'b00);
        ALARMA = 1'b0;
        cyc("key_idle", 2'b00);

        // alarm drop during beep
        ALARMA = 1'b1;
        beep_run("beep_g", 0, 2);
        ALARMA = 1'b0;
        hold("drop_idle", 3, 2'b00);

        // asynchronous reset with speaker high
        ALARMA = 1'b1;
        beep_run("beep_h", 0, 2);
        #2;
        RST = 1'b0;
        #1;
        check("arst_spk", {7'b0, speaker}, 8'h00);
        check("arst_act", {7'b0, ALARM_ACTIVE}, 8'h00);
        ALARMA = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        check("rel_act", {7'b0, ALARM_ACTIVE}, 8'h00);
        cyc("rel_idle", 2'b00);
        ALARMA = 1'b1;
        beep_run("rel_beep", 0, 2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
